cube_regfile: RTL and testbench
===============================

# cube_regfile

Parametrised state register file for the Rubik's-cube solver datapath: the generalised successor of the fixed 16×24-bit file. It provides configurable width and depth, reset-time initial contents, and two combinational read ports with optional write bypass. It adds a one-cycle snapshot of the live cube-state registers into a shadow bank, a multi-cycle restore sequencer with a ready handshake, and a registered "solved" flag comparing live state against the ideal-state registers. It sits between the solver controller (which issues moves and backtracks via snapshot/restore) and the face-rotation ALU.

## Interface
Parameters:
- DATA_W, 24, bits per register (one face encoding)
- DEPTH, 16, number of registers; legal 2..2**ADDR_W
- ADDR_W, 4, address width
- NUM_STATE, 3, live state registers at 0..NUM_STATE-1; legal 1..DEPTH/2
- IDEAL_BASE, 9, first ideal-state register; IDEAL_BASE+NUM_STATE ≤ DEPTH; ranges must not overlap
- BYPASS, 1, 1 = read of the address being written returns the write data in the same cycle
- INIT_VEC, {DEPTH*DATA_W{1'b0}}, reset contents; reg i = INIT_VEC[i*DATA_W +: DATA_W]

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- src0  in  ADDR_W  read address, port 0
- src1  in  ADDR_W  read address, port 1
- data0  out  DATA_W  read data, port 0 (combinational)
- data1  out  DATA_W  read data, port 1 (combinational)
- we  in  1  write enable
- dst  in  ADDR_W  write address
- data  in  DATA_W  write data
- wr_ready  out  1  high when a write, save, or restore is accepted this cycle
- save_req  in  1  copy regs 0..NUM_STATE-1 into the shadow bank
- restore_req  in  1  start copying shadow bank back into regs 0..NUM_STATE-1
- restore_done  out  1  one-cycle pulse on the last restore write
- solved  out  1  reg k == reg IDEAL_BASE+k for all k < NUM_STATE

## Operation
- Reset (rst_n low, async):
  - reg i ← INIT_VEC slice i.
  - Shadow k ← INIT_VEC slice k.
  - Sequencer → IDLE; wr_ready=1, restore_done=0, solved=0.
- States: IDLE, RESTORE. A counter idx (width ≥ clog2(NUM_STATE)) tracks restore progress.
- IDLE behaviour:
  - wr_ready=1.
  - we=1 with dst < DEPTH: reg[dst] ← data. dst ≥ DEPTH is ignored.
  - save_req=1 and restore_req=0: shadow k ← reg k for all k, using pre-edge values. A same-cycle write to reg k is not captured.
  - restore_req=1: go to RESTORE with idx=0. A simultaneous save_req is ignored. A simultaneous we still writes.
- RESTORE behaviour:
  - wr_ready=0. we, save_req, and restore_req are ignored.
  - Each cycle: reg[idx] ← shadow[idx], then idx++.
  - On idx = NUM_STATE-1: restore_done=1 that cycle, return to IDLE next edge.
- Reads:
  - Address ≥ DEPTH returns 0.
  - BYPASS=1: if the read address equals the write address with an accepted write this cycle, return `data`.
  - Restore writes are never bypassed.
- solved: registered; at each edge it samples the comparison of current register contents (pre-edge values).

## Timing
- Write latency: 1 edge; visible on data0/1 the same cycle when BYPASS=1, the next cycle when BYPASS=0.
- Save: 1 edge. Shadow is updated after the edge.
- Restore: the request edge enters RESTORE, followed by NUM_STATE write edges. wr_ready is low for exactly NUM_STATE cycles. restore_done is a combinational decode of (RESTORE && idx==NUM_STATE-1).
- solved lags register contents by 1 cycle. A write that completes the match at edge N gives solved=1 after edge N+1.
- Reset asserted mid-restore: abort immediately and reload INIT_VEC. No partial restore survives.
- Back-to-back restore: a restore_req in the cycle after restore_done is accepted.

## Test plan
- Reset with the default cube INIT_VEC (reg0=24'h8000C1, reg1=24'h081408, reg2=24'h132000, reg9=24'hF00000, reg10=24'h0F0000, reg11=24'h00F000):
  - src0=0 → data0=24'h8000C1.
  - src1=15 → 0.
  - solved=0, wr_ready=1.
- Write bypass: we=1, dst=3, data=24'hABCDEF, src0=3.
  - BYPASS=1 → data0=24'hABCDEF the same cycle.
  - BYPASS=0 → old value that cycle, 24'hABCDEF the next.
- Solve detection: write reg0/1/2 with 24'hF00000/24'h0F0000/24'h00F000 on consecutive cycles.
  - solved=1 exactly one cycle after the third write edge.
  - Overwrite reg1 → solved=0 one cycle later.
- Snapshot/restore: save_req with reg0..2 = A,B,C; write reg0..2 = X,Y,Z; restore_req.
  - wr_ready low for 3 cycles.
  - A we during RESTORE is dropped.
  - restore_done pulses on the third cycle.
  - Reads then return A,B,C.
- Simultaneous events:
  - save_req+restore_req: only the restore occurs, and the shadow is unchanged.
  - save_req+we to reg1: the shadow captures the old reg1.
- Async reset at restore cycle 2: all regs return to INIT_VEC with no clock edge needed; wr_ready=1, restore_done=0.

Source files
------------

// File: rtl/cube_regfile.sv
// Parametrised cube-state register file with two combinational read ports,
// a shadow snapshot bank, a multi-cycle restore sequencer and a solved flag.
module cube_regfile #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned NUM_STATE  = 3,
  parameter int unsigned IDEAL_BASE = 9,
  parameter bit          BYPASS     = 1'b1,
  parameter logic [DEPTH*DATA_W-1:0] INIT_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] src0,
  input  logic [ADDR_W-1:0] src1,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  input  logic              we,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] data,
  output logic              wr_ready,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              restore_done,
  output logic              solved
);

  localparam int unsigned IDX_W = (NUM_STATE > 1) ? $clog2(NUM_STATE) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATE - 1);

  typedef enum logic {IDLE, RESTORE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] regs_q   [DEPTH];
  logic [DATA_W-1:0] shadow_q [NUM_STATE];
  logic              solved_q;
  logic              wr_acc;
  logic              save_acc;
  logic              match;

  assign wr_acc   = (state_q == IDLE) && we && ({1'b0, dst} < DEPTH_A);
  assign save_acc = (state_q == IDLE) && save_req && !restore_req;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (restore_req) begin
          state_d = RESTORE;
          idx_d   = '0;
        end
      end
      RESTORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer outputs
  always_comb begin
    wr_ready     = 1'b0;
    restore_done = 1'b0;
    case (state_q)
      IDLE:    wr_ready = 1'b1;
      RESTORE: restore_done = (idx_q == LAST_IDX);
      default: wr_ready = 1'b0;
    endcase
  end

  // Main register array: restore writes take priority and block external writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= INIT_VEC[i*DATA_W +: DATA_W];
    end else if (state_q == RESTORE) begin
      regs_q[ADDR_W'(idx_q)] <= shadow_q[idx_q];
    end else if (wr_acc) begin
      regs_q[dst] <= data;
    end
  end

  // Shadow bank captures pre-edge live state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STATE; k++) shadow_q[k] <= INIT_VEC[k*DATA_W +: DATA_W];
    end else if (save_acc) begin
      for (int k = 0; k < NUM_STATE; k++) shadow_q[k] <= regs_q[k];
    end
  end

  always_comb begin
    match = 1'b1;
    for (int k = 0; k < NUM_STATE; k++) begin
      if (regs_q[k] != regs_q[IDEAL_BASE + k]) match = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) solved_q <= 1'b0;
    else        solved_q <= match;
  end

  assign solved = solved_q;

  // Read ports; only external writes are forwarded
  always_comb begin
    data0 = '0;
    data1 = '0;
    if ({1'b0, src0} < DEPTH_A) data0 = regs_q[src0];
    if ({1'b0, src1} < DEPTH_A) data1 = regs_q[src1];
    if (BYPASS && wr_acc && (src0 == dst)) data0 = data;
    if (BYPASS && wr_acc && (src1 == dst)) data1 = data;
  end

endmodule

// File: tb/tb_cube_regfile.sv
// Directed bench for cube_regfile: bypass and non-bypass instances share stimulus,
// a behavioural model is compared every negedge, plus hand-computed literal checks.
module tb_cube_regfile;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NS    = 3;
  localparam int unsigned IB    = 9;
  localparam logic [DEPTH*DW-1:0] INIT = {
    24'h0, 24'h0, 24'h0, 24'h0,
    24'h00F000, 24'h0F0000, 24'hF00000,
    24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0,
    24'h132000, 24'h081408, 24'h8000C1};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] src0, src1, dst;
  logic [DW-1:0] data;
  logic          we, save_req, restore_req;
  logic [DW-1:0] b_d0, b_d1, n_d0, n_d1;
  logic          b_wr, b_done, b_sol, n_wr, n_done, n_sol;

  always #5 clk = ~clk;

  cube_regfile #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_STATE(NS),
                 .IDEAL_BASE(IB), .BYPASS(1'b1), .INIT_VEC(INIT)) dut_b (
    .clk(clk), .rst_n(rst_n), .src0(src0), .src1(src1), .data0(b_d0), .data1(b_d1),
    .we(we), .dst(dst), .data(data), .wr_ready(b_wr), .save_req(save_req),
    .restore_req(restore_req), .restore_done(b_done), .solved(b_sol));

  cube_regfile #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_STATE(NS),
                 .IDEAL_BASE(IB), .BYPASS(1'b0), .INIT_VEC(INIT)) dut_n (
    .clk(clk), .rst_n(rst_n), .src0(src0), .src1(src1), .data0(n_d0), .data1(n_d1),
    .we(we), .dst(dst), .data(data), .wr_ready(n_wr), .save_req(save_req),
    .restore_req(restore_req), .restore_done(n_done), .solved(n_sol));

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: register contents, shadow copy, restore writes remaining
  logic [DW-1:0] m_reg [DEPTH];
  logic [DW-1:0] m_sh  [NS];
  int            m_left;
  logic          m_solved;

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] pre [DEPTH];
    bit            all_eq;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_reg[i] = INIT[i*DW +: DW];
      for (int k = 0; k < NS; k++) m_sh[k] = INIT[k*DW +: DW];
      m_left   = 0;
      m_solved = 1'b0;
    end else begin
      pre    = m_reg;
      all_eq = 1'b1;
      for (int k = 0; k < NS; k++) if (pre[k] != pre[IB + k]) all_eq = 1'b0;
      if (m_left == 0) begin
        if (we) m_reg[dst] = data;
        if (restore_req) m_left = NS;
        else if (save_req) for (int k = 0; k < NS; k++) m_sh[k] = pre[k];
      end else begin
        m_reg[NS - m_left] = m_sh[NS - m_left];
        m_left--;
      end
      m_solved = all_eq;
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (byp && m_left == 0 && we && a == dst) return data;
    return m_reg[a];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_b_data0", 32'(b_d0), 32'(exp_read(src0, 1'b1)));
      chk("model_b_data1", 32'(b_d1), 32'(exp_read(src1, 1'b1)));
      chk("model_n_data0", 32'(n_d0), 32'(exp_read(src0, 1'b0)));
      chk("model_n_data1", 32'(n_d1), 32'(exp_read(src1, 1'b0)));
      chk("model_wr_ready", 32'({n_wr, b_wr}), 32'({2{m_left == 0}}));
      chk("model_restore_done", 32'({n_done, b_done}), 32'({2{m_left == 1}}));
      chk("model_solved", 32'({n_sol, b_sol}), 32'({2{m_solved}}));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    nxt();
    we = 1'b1; dst = a; data = d;
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; dst = '0; data = '0;
    src0 = 4'd0; src1 = 4'd15; save_req = 1'b0; restore_req = 1'b0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    nxt();
    nxt();
    rst_n = 1'b1;

    // Reset contents
    @(negedge clk);
    chk("reset_data0", 32'(b_d0), 32'h8000C1);
    chk("reset_data1", 32'(b_d1), 32'h0);
    chk("reset_solved", 32'(b_sol), 32'h0);
    chk("reset_wr_ready", 32'(b_wr), 32'h1);

    // Write bypass vs no bypass
    wr(4'd3, 24'hABCDEF);
    src0 = 4'd3;
    @(negedge clk);
    chk("bypass_same_cycle", 32'(b_d0), 32'hABCDEF);
    chk("nobypass_same_cycle", 32'(n_d0), 32'h0);
    nxt();
    we = 1'b0;
    @(negedge clk);
    chk("nobypass_next_cycle", 32'(n_d0), 32'hABCDEF);

    // Solve detection
    wr(4'd0, 24'hF00000);
    wr(4'd1, 24'h0F0000);
    wr(4'd2, 24'h00F000);
    nxt();
    we = 1'b0;
    @(negedge clk);
    chk("solved_after_N", 32'(b_sol), 32'h0);
    nxt();
    @(negedge clk);
    chk("solved_after_N1", 32'(b_sol), 32'h1);
    wr(4'd1, 24'h123456);
    nxt();
    we = 1'b0;
    @(negedge clk);
    chk("unsolve_after_M", 32'(b_sol), 32'h1);
    nxt();
    @(negedge clk);
    chk("unsolve_after_M1", 32'(b_sol), 32'h0);

    // Snapshot A,B,C with a same-cycle write to reg1, then overwrite with X,Y,Z
    wr(4'd1, 24'h777777);
    save_req = 1'b1;
    wr(4'd0, 24'h111111);
    save_req = 1'b0;
    wr(4'd1, 24'h222222);
    wr(4'd2, 24'h333333);
    // Restore with simultaneous save (ignored) and write (kept)
    wr(4'd5, 24'h555555);
    save_req = 1'b1; restore_req = 1'b1;
    @(negedge clk);
    chk("restore_req_ready", 32'(b_wr), 32'h1);
    wr(4'd4, 24'h444444);
    save_req = 1'b0; restore_req = 1'b0;
    src0 = 4'd4; src1 = 4'd5;
    @(negedge clk);
    chk("restore_c1_ready", 32'(b_wr), 32'h0);
    chk("restore_c1_done", 32'(b_done), 32'h0);
    chk("restore_no_bypass", 32'(b_d0), 32'h0);
    chk("write_with_restore_req", 32'(b_d1), 32'h555555);
    nxt();
    @(negedge clk);
    chk("restore_c2_ready", 32'(b_wr), 32'h0);
    chk("restore_c2_done", 32'(b_done), 32'h0);
    nxt();
    @(negedge clk);
    chk("restore_c3_ready", 32'(b_wr), 32'h0);
    chk("restore_c3_done", 32'(b_done), 32'h1);
    // Back-to-back restore request right after restore_done
    nxt();
    we = 1'b0; src0 = 4'd0; src1 = 4'd1; restore_req = 1'b1;
    @(negedge clk);
    chk("post_restore_ready", 32'(b_wr), 32'h1);
    chk("post_restore_done", 32'(b_done), 32'h0);
    chk("restored_reg0", 32'(b_d0), 32'hF00000);
    chk("restored_reg1_old", 32'(b_d1), 32'h123456);
    nxt();
    restore_req = 1'b0; src0 = 4'd2; src1 = 4'd4;
    @(negedge clk);
    chk("b2b_restore_accepted", 32'(b_wr), 32'h0);
    chk("restored_reg2", 32'(b_d0), 32'h00F000);
    chk("dropped_write_reg4", 32'(b_d1), 32'h0);

    // Async reset during restore cycle 2
    nxt();
    @(negedge clk);
    chk("b2b_c2_ready", 32'(b_wr), 32'h0);
    #2;
    src0 = 4'd0; src1 = 4'd1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_reg0", 32'(b_d0), 32'h8000C1);
    chk("async_rst_reg1", 32'(n_d1), 32'h081408);
    chk("async_rst_ready", 32'({n_wr, b_wr}), 32'h3);
    chk("async_rst_done", 32'({n_done, b_done}), 32'h0);
    nxt();
    rst_n = 1'b1;
    src0 = 4'd9; src1 = 4'd5;
    @(negedge clk);
    chk("after_rst_reg9", 32'(b_d0), 32'hF00000);
    chk("after_rst_reg5", 32'(b_d1), 32'h0);
    nxt();
    nxt();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
